// File: rtl/pmod_rx_pkg.sv
// pmod_rx_pkg: shared types and constants for the PMOD frame receiver.
//   rx_state_e  - frame state machine encoding
//   DEF_*       - default frame width, FIFO depth and synchronizer length
//   ERR_CNT_W   - width of the saturating frame-error counter
package pmod_rx_pkg;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned ERR_CNT_W       = 8;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_e;

  // Increment that holds at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: DEPTH x WIDTH show-ahead FIFO for received frames.
//   CLK, RST_N   - clock, asynchronous active-low reset
//   i_push       - write i_push_data (ignored when full unless popping too)
//   i_pop        - drop head entry (ignored when empty)
//   o_data       - head entry, valid whenever o_empty is low
//   o_full       - all DEPTH entries occupied
//   o_empty      - no entries
module rx_frame_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/pmod_frame_receiver.sv
// pmod_frame_receiver: receive side of the 3-wire PMOD serial link.
// Oversamples CS_N/SDAT/SCLK on CLK, deserializes LSB-first frames on SCLK
// falling edges, checks the bit count and queues good frames in a FIFO.
//   CLK, RST_N         - system clock, asynchronous active-low reset
//   CS_N_IN, SDAT_IN,
//   SCLK_IN            - asynchronous link pins
//   FRAME_DATA/VALID/
//   READY              - show-ahead valid/ready frame output
//   FRAME_ERR          - one-cycle pulse on a frame with bit count != WIDTH
//   OVERFLOW           - sticky: good frame dropped on a full FIFO
//   ERR_COUNT          - saturating count of FRAME_ERR pulses
//   BUSY               - receiving a frame
module pmod_frame_receiver
  import pmod_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CS_N_IN,
  input  logic                 SDAT_IN,
  input  logic                 SCLK_IN,
  output logic [WIDTH-1:0]     FRAME_DATA,
  output logic                 FRAME_VALID,
  input  logic                 FRAME_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERFLOW,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic                 BUSY
);

  localparam int unsigned CNT_W   = $clog2(WIDTH + 2);
  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(WIDTH + 1);
  localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(SYNC_STAGES + 1);

  // Input synchronizers and edge detection
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;
  logic                   w_cs;
  logic                   w_sdat;
  logic                   w_sclk;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_sclk_fall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cs_sync   <= '1;
      r_sdat_sync <= '0;
      r_sclk_sync <= '1;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   CS_N_IN};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], SDAT_IN};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK_IN};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sdat      = r_sdat_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  // The CS_N chain resets to 1, so right after reset it reads "idle" before
  // the real pin level has arrived. Hold WAIT_IDLE until the chain and the
  // edge-detect copy have been refilled from the pin.
  logic [PRIME_W-1:0] r_prime_cnt;
  logic               w_primed;

  assign w_primed = (r_prime_cnt == PRIME_END);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prime_cnt <= '0;
    end else if (!w_primed) begin
      r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
    end
  end

  // Frame state machine
  rx_state_e r_state;
  rx_state_e w_state_nxt;
  logic      w_frame_end;
  logic      w_push;
  logic      w_frame_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WAIT_IDLE: if (w_primed && w_cs) w_state_nxt = IDLE;
      IDLE:      if (w_cs_fall)        w_state_nxt = SHIFT;
      SHIFT:     if (w_cs_rise)        w_state_nxt = IDLE;
      default:                         w_state_nxt = WAIT_IDLE;
    endcase
  end

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    BUSY        = 1'b0;
    w_frame_end = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    if (r_state == SHIFT) begin
      BUSY        = 1'b1;
      w_frame_end = w_cs_rise;
      w_push      = w_cs_rise && (r_count == CNT_FULL);
      w_frame_err = w_cs_rise && (r_count != CNT_FULL);
    end
  end

  assign FRAME_ERR = w_frame_err;

  // Shift register and bit counter; the frame-end edge wins over a strobe
  // landing in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (r_state == IDLE && w_cs_fall) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (r_state == SHIFT && w_sclk_fall && !w_frame_end) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_count == CNT_W'(i)) begin
          r_shift[i] <= w_sdat;
        end
      end
      if (r_count != CNT_SAT) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Output FIFO, overflow flag and error counter
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic r_overflow;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign FRAME_VALID = ~w_empty;
  assign w_pop       = FRAME_VALID && FRAME_READY;

  rx_frame_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_data      (FRAME_DATA),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_err) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign OVERFLOW  = r_overflow;
  assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_pmod_frame_receiver.sv
// tb_pmod_frame_receiver: directed bench for pmod_frame_receiver.
// Drives the link pins like the pattern serializer (data changes with SCLK
// rising, 8-CLK SCLK period) and checks outputs on CLK falling edges.
module tb_pmod_frame_receiver;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CS_N_IN = 1'b1;
  logic        SDAT_IN = 1'b0;
  logic        SCLK_IN = 1'b0;
  logic        FRAME_READY = 1'b0;
  logic [15:0] FRAME_DATA;
  logic        FRAME_VALID;
  logic        FRAME_ERR;
  logic        OVERFLOW;
  logic [7:0]  ERR_COUNT;
  logic        BUSY;

  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;
  int err_base;

  pmod_frame_receiver #(
    .WIDTH       (16),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CS_N_IN     (CS_N_IN),
    .SDAT_IN     (SDAT_IN),
    .SCLK_IN     (SCLK_IN),
    .FRAME_DATA  (FRAME_DATA),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .FRAME_ERR   (FRAME_ERR),
    .OVERFLOW    (OVERFLOW),
    .ERR_COUNT   (ERR_COUNT),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST_N && FRAME_ERR) err_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cs_start;
    CS_N_IN = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      SCLK_IN = 1'b1;
      SDAT_IN = d[i];
      wait_clk(4);
      SCLK_IN = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic cs_end;
    wait_clk(4);
    CS_N_IN = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] d, input int n);
    cs_start();
    send_bits(d, n);
    cs_end();
    wait_clk(12);
  endtask

  logic [15:0] exp_q [4];

  initial begin
    // Reset state
    wait_clk(3);
    chk("rst_data",   32'(FRAME_DATA),  32'h0);
    chk("rst_valid",  32'(FRAME_VALID), 32'h0);
    chk("rst_err",    32'(FRAME_ERR),   32'h0);
    chk("rst_ovf",    32'(OVERFLOW),    32'h0);
    chk("rst_errcnt", 32'(ERR_COUNT),   32'h0);
    chk("rst_busy",   32'(BUSY),        32'h0);
    RST_N = 1'b1;
    wait_clk(10);

    // Single frame
    err_base = err_pulses;
    cs_start();
    chk("busy_in_frame", 32'(BUSY), 32'h1);
    send_bits(32'hE000, 16);
    cs_end();
    wait_clk(12);
    chk("f1_valid", 32'(FRAME_VALID), 32'h1);
    chk("f1_data",  32'(FRAME_DATA),  32'hE000);
    chk("f1_noerr", 32'(err_pulses - err_base), 32'h0);
    chk("f1_busy",  32'(BUSY), 32'h0);
    FRAME_READY = 1'b1;
    wait_clk(1);
    FRAME_READY = 1'b0;
    chk("f1_popped", 32'(FRAME_VALID), 32'h0);

    // Fill FIFO, fifth frame dropped, then back-to-back drain
    exp_q = '{16'h0001, 16'h00AA, 16'h5555, 16'hFFFF};
    for (int i = 0; i < 4; i++) send_frame(32'(exp_q[i]), 16);
    chk("full_ovf0", 32'(OVERFLOW), 32'h0);
    send_frame(32'h1234, 16);
    chk("full_ovf1", 32'(OVERFLOW), 32'h1);
    FRAME_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(FRAME_VALID), 32'h1);
      chk($sformatf("drain_data%0d", i),  32'(FRAME_DATA),  32'(exp_q[i]));
      wait_clk(1);
    end
    chk("drain_empty", 32'(FRAME_VALID), 32'h0);
    FRAME_READY = 1'b0;

    // Short and long frames
    err_base = err_pulses;
    send_frame(32'h0000_7FFF, 15);
    send_frame(32'h0001_FFFF, 17);
    chk("len_pulses", 32'(err_pulses - err_base), 32'h2);
    chk("len_errcnt", 32'(ERR_COUNT), 32'h2);
    chk("len_nopush", 32'(FRAME_VALID), 32'h0);
    chk("len_ovf_sticky", 32'(OVERFLOW), 32'h1);

    // CS_N held low across reset release
    CS_N_IN = 1'b0;
    RST_N = 1'b0;
    wait_clk(2);
    RST_N = 1'b1;
    wait_clk(5);
    err_base = err_pulses;
    send_bits(32'h3FF, 10);
    cs_end();
    wait_clk(12);
    chk("rip_nopush", 32'(FRAME_VALID), 32'h0);
    chk("rip_noerr",  32'(err_pulses - err_base), 32'h0);
    chk("rip_errcnt", 32'(ERR_COUNT), 32'h0);
    chk("rip_ovf",    32'(OVERFLOW), 32'h0);
    send_frame(32'h3B90, 16);
    chk("rip_next_valid", 32'(FRAME_VALID), 32'h1);
    chk("rip_next_data",  32'(FRAME_DATA),  32'h3B90);
    FRAME_READY = 1'b1;
    wait_clk(1);
    FRAME_READY = 1'b0;

    // Push and pop in the same cycle on a full FIFO
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) send_frame(32'(exp_q[i]), 16);
    cs_start();
    send_bits(32'h0F0F, 16);
    cs_end();
    // CS_N rise takes two CLK edges to reach the detector; push on the third.
    wait_clk(2);
    chk("pp_busy_before", 32'(BUSY), 32'h1);
    FRAME_READY = 1'b1;
    wait_clk(1);
    FRAME_READY = 1'b0;
    chk("pp_busy_after", 32'(BUSY), 32'h0);
    chk("pp_ovf", 32'(OVERFLOW), 32'h0);
    wait_clk(5);
    exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'h0F0F};
    FRAME_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_data%0d", i), 32'(FRAME_DATA), 32'(exp_q[i]));
      wait_clk(1);
    end
    chk("pp_empty", 32'(FRAME_VALID), 32'h0);
    FRAME_READY = 1'b0;

    // Reset mid-frame
    send_frame(32'hBEEF, 16);
    send_frame(32'h5, 3);
    chk("mr_pre_valid",  32'(FRAME_VALID), 32'h1);
    chk("mr_pre_errcnt", 32'(ERR_COUNT),   32'h1);
    cs_start();
    send_bits(32'hA5, 8);
    chk("mr_pre_busy", 32'(BUSY), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("mr_data",   32'(FRAME_DATA),  32'h0);
    chk("mr_valid",  32'(FRAME_VALID), 32'h0);
    chk("mr_err",    32'(FRAME_ERR),   32'h0);
    chk("mr_ovf",    32'(OVERFLOW),    32'h0);
    chk("mr_errcnt", 32'(ERR_COUNT),   32'h0);
    chk("mr_busy",   32'(BUSY),        32'h0);
    wait_clk(1);
    CS_N_IN = 1'b1;
    wait_clk(2);
    RST_N = 1'b1;
    wait_clk(10);

    // Error counter saturation
    err_base = err_pulses;
    repeat (300) send_frame(32'h1, 1);
    chk("sat_pulses", 32'(err_pulses - err_base), 32'd300);
    chk("sat_errcnt", 32'(ERR_COUNT), 32'd255);
    chk("sat_nopush", 32'(FRAME_VALID), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
